// File: rtl/mfp_ahb_gpio_ext.sv
// mfp_ahb_gpio_ext: parametrised AHB-Lite GPIO slave with debounced inputs, LED set/clear, edge status and IRQ
//   HCLK/HRESET     : clock, synchronous active-high reset
//   HADDR..HSEL     : AHB-Lite slave inputs (HADDR is a word index)
//   HRDATA          : registered read data
//   IO_Switch/IO_PB : raw asynchronous inputs
//   IO_LED          : LED drive
//   IRQ             : registered level interrupt

// mfp_ahb_gpio_db: 2-flop synchroniser plus 3-sample agreement debouncer
//   tick : sample strobe; d : raw input; q : debounced; qd : q delayed one cycle
module mfp_ahb_gpio_db #(parameter int W = 1) (
  input  logic         HCLK,
  input  logic         HRESET,
  input  logic         tick,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] qd
);
  logic [W-1:0] s1, s2, h0, h1, agree;
  // The three history entries are the incoming sample and the two previous ones,
  // so the debounced bit moves on the same tick that the third agreeing sample arrives.
  assign agree = ~(s2 ^ h0) & ~(h0 ^ h1);
  always_ff @(posedge HCLK)
    if (HRESET) begin
      s1 <= '0;
      s2 <= '0;
      h0 <= '0;
      h1 <= '0;
      q  <= '0;
      qd <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      qd <= q;
      if (tick) begin
        h0 <= s2;
        h1 <= h0;
        q  <= (agree & s2) | (~agree & q);
      end
    end
endmodule

module mfp_ahb_gpio_ext #(
  parameter int N_LED    = 16,
  parameter int N_SW     = 16,
  parameter int N_PB     = 5,
  parameter int DB_COUNT = 50000
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [3:0]       HADDR,
  input  logic [1:0]       HTRANS,
  input  logic [31:0]      HWDATA,
  input  logic             HWRITE,
  input  logic             HSEL,
  output logic [31:0]      HRDATA,
  input  logic [N_SW-1:0]  IO_Switch,
  input  logic [N_PB-1:0]  IO_PB,
  output logic [N_LED-1:0] IO_LED,
  output logic             IRQ
);
  localparam int CW = DB_COUNT > 1 ? $clog2(DB_COUNT) : 1;
  logic [3:0]      addr_d;
  logic [1:0]      trans_d;
  logic            write_d, sel_d, we, tick;
  logic [CW-1:0]   cnt;
  logic [N_SW-1:0] sw_q, sw_qd, sw_edge, sw_ie, sw_clr;
  logic [N_PB-1:0] pb_q, pb_qd, pb_edge, pb_ie, pb_clr;
  logic [N_LED-1:0] wl, led_n;
  logic [31:0]     rd;
  assign we    = sel_d & write_d & (trans_d != 2'b00);
  assign tick  = cnt == CW'(DB_COUNT - 1);
  assign wl    = HWDATA[N_LED-1:0];
  assign sw_clr = we && addr_d == 4'd7 ? HWDATA[N_SW-1:0] : '0;
  assign pb_clr = we && addr_d == 4'd5 ? HWDATA[N_PB-1:0] : '0;
  mfp_ahb_gpio_db #(.W(N_SW)) u_sw (.HCLK, .HRESET, .tick, .d(IO_Switch), .q(sw_q), .qd(sw_qd));
  mfp_ahb_gpio_db #(.W(N_PB)) u_pb (.HCLK, .HRESET, .tick, .d(IO_PB), .q(pb_q), .qd(pb_qd));
  always_comb begin
    led_n = !we              ? IO_LED :
            addr_d == 4'd0   ? wl :
            addr_d == 4'd3   ? IO_LED | wl :
            addr_d == 4'd4   ? IO_LED & ~wl : IO_LED;
    case (HADDR)
      4'd0, 4'd3, 4'd4: rd = 32'(IO_LED);
      4'd1:             rd = 32'(sw_q);
      4'd2:             rd = 32'(pb_q);
      4'd5:             rd = 32'(pb_edge);
      4'd6:             rd = 32'(pb_ie);
      4'd7:             rd = 32'(sw_edge);
      4'd8:             rd = 32'(sw_ie);
      default:          rd = '0;
    endcase
  end
  always_ff @(posedge HCLK)
    if (HRESET) begin
      addr_d  <= '0;
      trans_d <= '0;
      write_d <= 1'b0;
      sel_d   <= 1'b0;
      cnt     <= '0;
      IO_LED  <= '0;
      HRDATA  <= '0;
      IRQ     <= 1'b0;
      sw_edge <= '0;
      pb_edge <= '0;
      sw_ie   <= '0;
      pb_ie   <= '0;
    end else begin
      addr_d  <= HADDR;
      trans_d <= HTRANS;
      write_d <= HWRITE;
      sel_d   <= HSEL;
      cnt     <= tick ? '0 : cnt + CW'(1);
      IO_LED  <= led_n;
      HRDATA  <= rd;
      IRQ     <= |(pb_edge & pb_ie) | |(sw_edge & sw_ie);
      // A new edge in the same cycle as its W1C clear survives the clear.
      pb_edge <= (pb_edge & ~pb_clr) | (pb_q & ~pb_qd);
      sw_edge <= (sw_edge & ~sw_clr) | (sw_q ^ sw_qd);
      if (we && addr_d == 4'd6) pb_ie <= HWDATA[N_PB-1:0];
      if (we && addr_d == 4'd8) sw_ie <= HWDATA[N_SW-1:0];
    end
endmodule
